dtw_accumulator_2f: RTL and testbench

//  Downstream of the 2-feature euclidean distance stage. Consumes its per-cell local distance d(j,i) stream
//  and computes the DTW cumulative cost D(j,i) = d + min(D(j-1,i), D(j,i-1), D(j-1,i-1)).

---
 rtl/dtw_accumulator_2f.sv | 164 ++++++++++++++++
 tb/tb_dtw_accumulator_2f.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dtw_accumulator_2f.sv
// DTW cumulative-cost accumulator over a 2-feature local distance stream, single row buffer.
// Optional Sakoe-Chiba band limiting is enabled with `define DTW_WINDOW_EN.
module dtw_accumulator_2f #(
  parameter int unsigned D_WIDTH          = 24,
  parameter int unsigned ACC_WIDTH        = 32,
  parameter int unsigned MAX_TEMPLATE_LEN = 64,
  parameter int unsigned LEN_W            = 7,
  parameter int unsigned WINDOW           = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     template_len,
  input  logic [LEN_W-1:0]     test_len,
  input  logic                 dist_valid,
  output logic                 dist_ready,
  input  logic [D_WIDTH-1:0]   dist_data,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_WIDTH-1:0] dtw_out,
  output logic                 overflow,
  output logic                 len_err
);

  localparam int unsigned AW = (MAX_TEMPLATE_LEN > 1) ? $clog2(MAX_TEMPLATE_LEN) : 1;
  localparam logic [ACC_WIDTH-1:0] ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     i_q, i_d, j_q, j_d, tl_q, tl_d, tst_q, tst_d;
  logic [ACC_WIDTH-1:0] left_q, left_d, diag_q, diag_d, dtw_q, dtw_d;
  logic                 done_q, done_d, ovf_q, ovf_d, lerr_q, lerr_d;
  logic [ACC_WIDTH-1:0] row_q [MAX_TEMPLATE_LEN];

  logic                 xfer, len_ok, last_i, last_j;
  logic [ACC_WIDTH-1:0] d_ext, up, m_ul, m_all, opnd, cell_d;
  logic                 cell_ovf;

  // All-ones operands are infinite: they propagate without flagging overflow.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a == ONES || b == ONES) return {1'b0, ONES};
    if (s >= {1'b0, ONES})      return {1'b1, ONES};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  always_comb begin
    xfer   = (state_q == S_RUN) && dist_valid;
    len_ok = (template_len != '0) && (32'(template_len) <= MAX_TEMPLATE_LEN) && (test_len != '0);
    last_i = (i_q == tl_q - LEN_W'(1));
    last_j = (j_q == tst_q - LEN_W'(1));
    d_ext  = ACC_WIDTH'(dist_data);
    up     = row_q[i_q[AW-1:0]];
    m_ul   = (up < left_q) ? up : left_q;
    m_all  = (m_ul < diag_q) ? m_ul : diag_q;
    if (i_q == '0 && j_q == '0) opnd = '0;
    else if (j_q == '0)         opnd = left_q;
    else if (i_q == '0)         opnd = up;
    else                        opnd = m_all;
    {cell_ovf, cell_d} = sat_add(d_ext, opnd);
`ifdef DTW_WINDOW_EN
    if (32'((i_q >= j_q) ? (i_q - j_q) : (j_q - i_q)) > WINDOW) begin
      cell_d   = ONES;
      cell_ovf = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    tl_d    = tl_q;
    tst_d   = tst_q;
    left_d  = left_q;
    diag_d  = diag_q;
    dtw_d   = dtw_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    lerr_d  = lerr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          tl_d  = template_len;
          tst_d = test_len;
          i_d   = '0;
          j_d   = '0;
          ovf_d = 1'b0;
          if (len_ok) begin
            state_d = S_RUN;
            lerr_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            dtw_d   = ONES;
            lerr_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (xfer) begin
          left_d = cell_d;
          diag_d = up;
          ovf_d  = ovf_q | cell_ovf;
          if (last_i) begin
            i_d = '0;
            j_d = j_q + LEN_W'(1);
            if (last_j) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              dtw_d   = cell_d;
            end
          end else begin
            i_d = i_q + LEN_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      tl_q    <= '0;
      tst_q   <= '0;
      left_q  <= '0;
      diag_q  <= '0;
      dtw_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      tl_q    <= tl_d;
      tst_q   <= tst_d;
      left_q  <= left_d;
      diag_q  <= diag_d;
      dtw_q   <= dtw_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      lerr_q  <= lerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) row_q[i_q[AW-1:0]] <= cell_d;
  end

  assign dist_ready = (state_q == S_RUN);
  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign dtw_out    = dtw_q;
  assign overflow   = ovf_q;
  assign len_err    = lerr_q;

endmodule

// File: tb/tb_dtw_accumulator_2f.sv
// Scoreboard bench for dtw_accumulator_2f: directed matrices, expected results queued at start.
module tb_dtw_accumulator_2f;

  localparam int unsigned DW  = 24;
  localparam int unsigned AW  = 24;
  localparam int unsigned LW  = 7;
`ifdef DTW_WINDOW_EN
  localparam int unsigned WIN = 0;
`else
  localparam int unsigned WIN = 8;
`endif
  localparam logic [AW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] template_len = '0;
  logic [LW-1:0] test_len = '0;
  logic          dist_valid = 1'b0;
  logic          dist_ready;
  logic [DW-1:0] dist_data = '0;
  logic          busy, done, overflow, len_err;
  logic [AW-1:0] dtw_out;

  dtw_accumulator_2f #(
    .D_WIDTH(DW), .ACC_WIDTH(AW), .MAX_TEMPLATE_LEN(64), .LEN_W(LW), .WINDOW(WIN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .template_len(template_len),
    .test_len(test_len), .dist_valid(dist_valid), .dist_ready(dist_ready),
    .dist_data(dist_data), .busy(busy), .done(done), .dtw_out(dtw_out),
    .overflow(overflow), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] dtw;
    logic          ovf;
    logic          lerr;
    string         name;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] dq[$];
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_dtw"}, 32'(dtw_out), 32'(e.dtw));
        check({e.name, "_ovf"}, 32'(overflow), 32'(e.ovf));
        check({e.name, "_lerr"}, 32'(len_err), 32'(e.lerr));
      end
    end
  end

  // Streams dq as one matrix; the start is expected to be legal.
  task automatic run_matrix(input int tl, input int tst, input bit gaps,
                            input logic [AW-1:0] exp_dtw, input logic exp_ovf, input string name);
    int n;
    n = dq.size();
    @(negedge clk);
    start = 1'b1; template_len = LW'(tl); test_len = LW'(tst);
    sb.push_back('{exp_dtw, exp_ovf, 1'b0, name});
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (gaps && (k % 2 == 1)) begin
        dist_valid = 1'b0;
        if (k == 1) begin
          start = 1'b1; template_len = LW'(1); test_len = LW'(1);
        end
        @(negedge clk);
        start = 1'b0;
      end
      dist_valid = 1'b1;
      dist_data  = dq[k];
      if (!dist_ready) check({name, "_ready"}, 32'(dist_ready), 32'd1);
      @(posedge clk);
      if (k == n - 1) begin
        #1;
        check({name, "_done_lat"}, 32'(done), 32'd1);
        check({name, "_busy_off"}, 32'(busy), 32'd0);
      end
      @(negedge clk);
    end
    dist_valid = 1'b0;
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    dq.delete();
  endtask

  task automatic bad_start(input int tl, input int tst, input string name);
    @(negedge clk);
    start = 1'b1; template_len = LW'(tl); test_len = LW'(tst);
    sb.push_back('{ONES, 1'b0, 1'b1, name});
    @(posedge clk);
    #1;
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_noready"}, 32'(dist_ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(dist_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dtw", 32'(dtw_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_lerr", 32'(len_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(dist_ready), 32'd0);

    dq = '{24'd5};
    run_matrix(1, 1, 1'b0, 24'd5, 1'b0, "t1");

    dq = '{24'd1, 24'd2, 24'd3, 24'd4};
    run_matrix(2, 2, 1'b0, 24'd5, 1'b0, "t2");

    dq = '{24'd0, 24'd10, 24'd10, 24'd10, 24'd0, 24'd10, 24'd10, 24'd10, 24'd0};
    run_matrix(3, 3, 1'b1, 24'd0, 1'b0, "t3");
    check("t3_ready_done", 32'(dist_ready), 32'd0);

    dq = '{24'hFFFFFE, 24'h000005};
`ifdef DTW_WINDOW_EN
    run_matrix(2, 1, 1'b0, ONES, 1'b0, "t4");
`else
    run_matrix(2, 1, 1'b0, ONES, 1'b1, "t4");
`endif

    bad_start(0, 3, "t5_tl0");
    bad_start(65, 2, "t5_tl65");
    bad_start(4, 0, "t5_tst0");
    dq = '{24'd7};
    run_matrix(1, 1, 1'b0, 24'd7, 1'b0, "t5_legal");

    @(negedge clk);
    start = 1'b1; template_len = LW'(3); test_len = LW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dist_valid = 1'b1; dist_data = DW'(k + 1);
      @(negedge clk);
    end
    dist_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(dist_ready), 32'd0);
    check("rst_mid_dtw", 32'(dtw_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dq = '{24'd1, 24'd2, 24'd3, 24'd2, 24'd3, 24'd4, 24'd3, 24'd4, 24'd5};
    run_matrix(3, 3, 1'b0, 24'd9, 1'b0, "t6");

    for (int k = 0; k < 128; k++) dq.push_back(24'd1);
`ifdef DTW_WINDOW_EN
    run_matrix(64, 2, 1'b0, ONES, 1'b0, "tmax");
`else
    run_matrix(64, 2, 1'b0, 24'd64, 1'b0, "tmax");
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
